// File: rtl/clk_btn_gen.sv
// Board-clock divider plus 2-FF sync, debounce and clk_div-aligned press pulse for the LED chaser.
// Latency: press -> button at first clk_div fall tick after DEBOUNCE_CYC+3 cycles; no backpressure.
module clk_btn_gen #(
    parameter int DIV_HALF     = 5_000_000,
    parameter int DEBOUNCE_CYC = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic clk_div,
    output logic button
);

    localparam int DIV_W = $clog2(DIV_HALF);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV_HALF - 1);
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYC - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_PULSE = 1'b1
    } state_t;

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_clk_div;
    logic             r_sync1;
    logic             r_sync2;
    logic [DB_W-1:0]  r_db_cnt;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_pending;
    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_serve;
    logic             w_div_wrap;
    logic             w_fall_tick;
    logic             w_press;

    assign w_div_wrap  = (r_div_cnt == DIV_MAX);
    assign w_fall_tick = w_div_wrap & r_clk_div;
    assign w_press     = r_stable & ~r_stable_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_clk_div <= 1'b0;
        end else if (w_div_wrap) begin
            r_div_cnt <= '0;
            r_clk_div <= ~r_clk_div;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_cnt   <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
        end else begin
            r_sync1    <= button_raw;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            // Any sample back at the stable level restarts the persistence count.
            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_MAX) begin
                r_stable <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_state   <= S_IDLE;
        end else begin
            r_pending <= w_press | (r_pending & ~w_serve);
            r_state   <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_serve     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall_tick && r_pending) begin
                    w_state_nxt = S_PULSE;
                    w_serve     = 1'b1;
                end
            end
            S_PULSE: begin
                // A press caught during the pulse extends it by one more clk_div period.
                if (w_fall_tick) begin
                    if (r_pending) begin
                        w_serve = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign clk_div = r_clk_div;
    assign button  = (r_state == S_PULSE);

endmodule
